// File: rtl/lstm_pkg.sv
// Shared LSTM definitions: fixed-point format defaults, width helpers and the
// operand-server state encoding.
package lstm_pkg;

  localparam int QN_DEFAULT = 6;
  localparam int QM_DEFAULT = 11;

  function automatic int bitwidth(input int qn, input int qm);
    return qn + qm + 1;
  endfunction

  function automatic int flog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      r = ((v >> i) > 1) ? i + 1 : r;
    end
    return r;
  endfunction

  typedef enum logic [2:0] {
    LOAD_WX = 3'd0,
    LOAD_WY = 3'd1,
    LOAD_B  = 3'd2,
    LOAD_X  = 3'd3,
    START   = 3'd4,
    BUSY    = 3'd5
  } srv_state_e;

endpackage

// File: rtl/gate_operand_server_col_store.sv
// col_store: column-organised weight register array with a single word-write
// port and a zero-latency whole-column read port.
module col_store
  import lstm_pkg::*;
#(
  parameter int ROWS   = 16,
  parameter int COLS   = 2,
  parameter int BW     = 18,
  parameter int ROW_AW = 4,
  parameter int COL_AW = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [ROW_AW-1:0]    wr_row,
  input  logic [COL_AW-1:0]    wr_col,
  input  logic [BW-1:0]        wr_data,
  input  logic                 wr_en,
  input  logic [COL_AW-1:0]    rd_col,
  output logic [ROWS*BW-1:0]   rd_data
);

  logic [ROWS*BW-1:0] mem_r [COLS];
  logic [COL_AW-1:0]  rd_sel_s;

  // Word write; row r of a column occupies bits [r*BW +: BW].
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int c = 0; c < COLS; c++) begin
        mem_r[c] <= '0;
      end
    end else if (wr_en) begin
      mem_r[wr_col][wr_row*BW +: BW] <= wr_data;
    end
  end

  // Out-of-range column requests fall back to column 0.
  always_comb begin
    if (int'(rd_col) < COLS) begin
      rd_sel_s = rd_col;
    end else begin
      rd_sel_s = '0;
    end
    rd_data = mem_r[rd_sel_s];
  end

endmodule

// File: rtl/gate_operand_server.sv
// gate_operand_server: serial-loaded operand source for one LSTM gate.
// Optional `GATE_SRV_RELOAD_EN adds the reloadWeights input.
module gate_operand_server
  import lstm_pkg::*;
#(
  parameter int INPUT_SZ  = 2,
  parameter int HIDDEN_SZ = 16,
  parameter int QN        = QN_DEFAULT,
  parameter int QM        = QM_DEFAULT,
  localparam int BITWIDTH        = bitwidth(QN, QM),
  localparam int LAYER_BITWIDTH  = BITWIDTH * HIDDEN_SZ,
  localparam int ADDR_BITWIDTH_X = flog2(INPUT_SZ),
  localparam int ADDR_BITWIDTH   = flog2(HIDDEN_SZ)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic signed [BITWIDTH-1:0] loadData,
  input  logic                       loadValid,
  output logic                       loadReady,
  input  logic [LAYER_BITWIDTH-1:0]  hiddenIn,
  input  logic                       hiddenValid,
  input  logic [ADDR_BITWIDTH_X-1:0] colAddress_X,
  input  logic [ADDR_BITWIDTH-1:0]   colAddress_Y,
  output logic [LAYER_BITWIDTH-1:0]  weightMem_X,
  output logic [LAYER_BITWIDTH-1:0]  weightMem_Y,
  output logic [LAYER_BITWIDTH-1:0]  biasVec,
  output logic [BITWIDTH-1:0]        inputVec,
  output logic [BITWIDTH-1:0]        prevLayerOut,
  output logic                       beginCalc,
  input  logic                       dataReady_gate,
`ifdef GATE_SRV_RELOAD_EN
  input  logic                       reloadWeights,
`endif
  output logic                       weightsLoaded
);

  localparam int CW = ADDR_BITWIDTH + 1;

  srv_state_e                  state_r;
  srv_state_e                  state_next_s;
  logic [CW-1:0]               row_cnt_r;
  logic [CW-1:0]               col_cnt_r;
  logic [LAYER_BITWIDTH-1:0]   bias_r;
  logic [LAYER_BITWIDTH-1:0]   h_r;
  logic [INPUT_SZ*BITWIDTH-1:0] x_r;
  logic                        weights_loaded_r;
  logic                        accept_s;
  logic                        row_last_s;
  logic                        wx_col_last_s;
  logic                        wy_col_last_s;
  logic                        x_last_s;
  logic                        reload_now_s;
  logic                        wx_we_s;
  logic                        wy_we_s;
  logic [ADDR_BITWIDTH_X-1:0]  x_sel_s;

`ifdef GATE_SRV_RELOAD_EN
  logic reload_pend_r;

  // A reload requested while the gate is running waits for the return to LOAD_X.
  always_ff @(posedge clock) begin
    if (reset) begin
      reload_pend_r <= 1'b0;
    end else if (state_r == LOAD_X) begin
      reload_pend_r <= 1'b0;
    end else if (reloadWeights && (state_r == BUSY || state_r == START)) begin
      reload_pend_r <= 1'b1;
    end else begin
      reload_pend_r <= reload_pend_r;
    end
  end

  assign reload_now_s = (state_r == LOAD_X) && (reloadWeights || reload_pend_r);
`else
  assign reload_now_s = 1'b0;
`endif

  assign accept_s      = loadValid & loadReady;
  assign row_last_s    = (row_cnt_r == CW'(HIDDEN_SZ - 1));
  assign wx_col_last_s = (col_cnt_r == CW'(INPUT_SZ - 1));
  assign wy_col_last_s = (col_cnt_r == CW'(HIDDEN_SZ - 1));
  assign x_last_s      = (row_cnt_r == CW'(INPUT_SZ - 1));
  assign wx_we_s       = accept_s && (state_r == LOAD_WX);
  assign wy_we_s       = accept_s && (state_r == LOAD_WY);

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= LOAD_WX;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic: each load section ends on its last accepted word.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      LOAD_WX: begin
        if (accept_s && row_last_s && wx_col_last_s) state_next_s = LOAD_WY;
        else                                          state_next_s = LOAD_WX;
      end
      LOAD_WY: begin
        if (accept_s && row_last_s && wy_col_last_s) state_next_s = LOAD_B;
        else                                          state_next_s = LOAD_WY;
      end
      LOAD_B: begin
        if (accept_s && row_last_s) state_next_s = LOAD_X;
        else                        state_next_s = LOAD_B;
      end
      LOAD_X: begin
        if (reload_now_s)               state_next_s = LOAD_WX;
        else if (accept_s && x_last_s)  state_next_s = START;
        else                            state_next_s = LOAD_X;
      end
      START:   state_next_s = BUSY;
      BUSY: begin
        if (dataReady_gate) state_next_s = LOAD_X;
        else                state_next_s = BUSY;
      end
      default: state_next_s = LOAD_WX;
    endcase
  end

  // Output decode.
  always_comb begin
    loadReady = 1'b0;
    beginCalc = 1'b0;
    case (state_r)
      LOAD_WX, LOAD_WY, LOAD_B: loadReady = 1'b1;
      LOAD_X:                   loadReady = !reload_now_s;
      START:                    beginCalc = 1'b1;
      BUSY:                     loadReady = 1'b0;
      default:                  loadReady = 1'b0;
    endcase
  end

  // Row/column counters; the row counter also indexes bias and x words.
  always_ff @(posedge clock) begin
    if (reset || reload_now_s) begin
      row_cnt_r <= '0;
      col_cnt_r <= '0;
    end else if (accept_s) begin
      case (state_r)
        LOAD_WX, LOAD_WY: begin
          if (row_last_s) begin
            row_cnt_r <= '0;
            if ((state_r == LOAD_WX && wx_col_last_s) || (state_r == LOAD_WY && wy_col_last_s)) begin
              col_cnt_r <= '0;
            end else begin
              col_cnt_r <= col_cnt_r + CW'(1);
            end
          end else begin
            row_cnt_r <= row_cnt_r + CW'(1);
          end
        end
        LOAD_B:  row_cnt_r <= row_last_s ? '0 : row_cnt_r + CW'(1);
        LOAD_X:  row_cnt_r <= x_last_s ? '0 : row_cnt_r + CW'(1);
        default: row_cnt_r <= row_cnt_r;
      endcase
    end
  end

  // Bias, x and h registers; h is frozen while the gate may be reading it.
  always_ff @(posedge clock) begin
    if (reset) begin
      bias_r           <= '0;
      x_r              <= '0;
      h_r              <= '0;
      weights_loaded_r <= 1'b0;
    end else begin
      if (accept_s && state_r == LOAD_B) begin
        bias_r[row_cnt_r[ADDR_BITWIDTH-1:0]*BITWIDTH +: BITWIDTH] <= loadData;
      end
      if (accept_s && state_r == LOAD_X) begin
        x_r[row_cnt_r[ADDR_BITWIDTH_X-1:0]*BITWIDTH +: BITWIDTH] <= loadData;
      end
      if (hiddenValid && (state_r == LOAD_X || state_r == START)) begin
        h_r <= hiddenIn;
      end
      if (reload_now_s) begin
        weights_loaded_r <= 1'b0;
      end else if (accept_s && state_r == LOAD_B && row_last_s) begin
        weights_loaded_r <= 1'b1;
      end
    end
  end

  always_comb begin
    if (int'(colAddress_X) < INPUT_SZ) begin
      x_sel_s = colAddress_X;
    end else begin
      x_sel_s = '0;
    end
  end

  assign weightsLoaded = weights_loaded_r;
  assign biasVec       = bias_r;
  assign inputVec      = x_r[x_sel_s*BITWIDTH +: BITWIDTH];
  assign prevLayerOut  = h_r[colAddress_Y*BITWIDTH +: BITWIDTH];

  col_store #(
    .ROWS(HIDDEN_SZ), .COLS(INPUT_SZ), .BW(BITWIDTH),
    .ROW_AW(ADDR_BITWIDTH), .COL_AW(ADDR_BITWIDTH_X)
  ) u_wx (
    .clock   (clock),
    .reset   (reset),
    .wr_row  (row_cnt_r[ADDR_BITWIDTH-1:0]),
    .wr_col  (col_cnt_r[ADDR_BITWIDTH_X-1:0]),
    .wr_data (loadData),
    .wr_en   (wx_we_s),
    .rd_col  (colAddress_X),
    .rd_data (weightMem_X)
  );

  col_store #(
    .ROWS(HIDDEN_SZ), .COLS(HIDDEN_SZ), .BW(BITWIDTH),
    .ROW_AW(ADDR_BITWIDTH), .COL_AW(ADDR_BITWIDTH)
  ) u_wy (
    .clock   (clock),
    .reset   (reset),
    .wr_row  (row_cnt_r[ADDR_BITWIDTH-1:0]),
    .wr_col  (col_cnt_r[ADDR_BITWIDTH-1:0]),
    .wr_data (loadData),
    .wr_en   (wy_we_s),
    .rd_col  (colAddress_Y),
    .rd_data (weightMem_Y)
  );

endmodule

// File: tb/tb_gate_operand_server.sv
// Self-checking bench for gate_operand_server (default build, reload feature off):
// random stimulus against an array-based reference of the stored operands.
module tb_gate_operand_server;

  localparam int IS = 2;
  localparam int HS = 16;
  localparam int BW = 18;
  localparam int LW = BW * HS;
  localparam int NW = IS*HS + HS*HS + HS;

  logic          clock = 1'b0;
  logic          reset;
  logic [BW-1:0] loadData;
  logic          loadValid;
  logic          loadReady;
  logic [LW-1:0] hiddenIn;
  logic          hiddenValid;
  logic [0:0]    colAddress_X;
  logic [3:0]    colAddress_Y;
  logic [LW-1:0] weightMem_X;
  logic [LW-1:0] weightMem_Y;
  logic [LW-1:0] biasVec;
  logic [BW-1:0] inputVec;
  logic [BW-1:0] prevLayerOut;
  logic          beginCalc;
  logic          dataReady_gate;
  logic          weightsLoaded;

  gate_operand_server dut (
    .clock(clock), .reset(reset), .loadData(loadData), .loadValid(loadValid),
    .loadReady(loadReady), .hiddenIn(hiddenIn), .hiddenValid(hiddenValid),
    .colAddress_X(colAddress_X), .colAddress_Y(colAddress_Y),
    .weightMem_X(weightMem_X), .weightMem_Y(weightMem_Y), .biasVec(biasVec),
    .inputVec(inputVec), .prevLayerOut(prevLayerOut), .beginCalc(beginCalc),
    .dataReady_gate(dataReady_gate), .weightsLoaded(weightsLoaded)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;
  int words = 0;

  logic [BW-1:0] m_wx [IS][HS];
  logic [BW-1:0] m_wy [HS][HS];
  logic [BW-1:0] m_b  [HS];
  logic [BW-1:0] m_x  [IS];
  logic [BW-1:0] m_h  [HS];
  logic [BW-1:0] wq [$];

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [LW-1:0] wx_col(input int c);
    logic [LW-1:0] v;
    for (int r = 0; r < HS; r++) v[r*BW +: BW] = m_wx[c][r];
    return v;
  endfunction

  function automatic logic [LW-1:0] wy_col(input int c);
    logic [LW-1:0] v;
    for (int r = 0; r < HS; r++) v[r*BW +: BW] = m_wy[c][r];
    return v;
  endfunction

  function automatic logic [LW-1:0] bias_vec();
    logic [LW-1:0] v;
    for (int r = 0; r < HS; r++) v[r*BW +: BW] = m_b[r];
    return v;
  endfunction

  function automatic logic [LW-1:0] rand_vec();
    logic [LW-1:0] v;
    for (int r = 0; r < HS; r++) v[r*BW +: BW] = BW'($urandom);
    return v;
  endfunction

  task automatic set_h(input logic [LW-1:0] v);
    for (int r = 0; r < HS; r++) m_h[r] = v[r*BW +: BW];
  endtask

  task automatic clear_model();
    for (int c = 0; c < IS; c++) for (int r = 0; r < HS; r++) m_wx[c][r] = '0;
    for (int c = 0; c < HS; c++) for (int r = 0; r < HS; r++) m_wy[c][r] = '0;
    for (int r = 0; r < HS; r++) begin m_b[r] = '0; m_h[r] = '0; end
    for (int i = 0; i < IS; i++) m_x[i] = '0;
  endtask

  // Stream order: W_x column-major, W_y column-major, bias.
  task automatic build_queue();
    wq.delete();
    for (int c = 0; c < IS; c++) for (int r = 0; r < HS; r++) wq.push_back(m_wx[c][r]);
    for (int c = 0; c < HS; c++) for (int r = 0; r < HS; r++) wq.push_back(m_wy[c][r]);
    for (int r = 0; r < HS; r++) wq.push_back(m_b[r]);
  endtask

  task automatic send_word(input logic [BW-1:0] d);
    int n;
    n = 0;
    loadValid = 1'b1;
    loadData = d;
    dataReady_gate = ($urandom_range(0, 7) == 0);
    #1;
    while (loadReady !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("load_ready_wait", LW'(loadReady), LW'(1'b1));
    tick();
    loadValid = 1'b0;
    dataReady_gate = 1'b0;
    words++;
    chk("weights_loaded", LW'(weightsLoaded), LW'(words >= NW));
    chk("begin_calc", LW'(beginCalc), LW'(words >= NW + IS && (words - NW) % IS == 0));
  endtask

  task automatic stream_weights(input int n, input int stall_at);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 5) == 0) tick();
      send_word(wq[i]);
      if (i + 1 == stall_at) begin
        for (int k = 0; k < 3; k++) begin
          dataReady_gate = (k == 1);
          tick();
          chk("stall_ready", LW'(loadReady), LW'(1'b1));
        end
        dataReady_gate = 1'b0;
      end
    end
  endtask

  task automatic stream_x(input logic [BW-1:0] a, input logic [BW-1:0] b,
                          input bit hv, input logic [LW-1:0] hvec);
    send_word(a);
    m_x[0] = a;
    hiddenValid = hv;
    hiddenIn = hvec;
    send_word(b);
    m_x[1] = b;
    hiddenValid = 1'b0;
    if (hv) set_h(hvec);
  endtask

  task automatic check_reads();
    int ax;
    int ay;
    ax = $urandom_range(0, IS - 1);
    ay = $urandom_range(0, HS - 1);
    colAddress_X = ax[0:0];
    colAddress_Y = ay[3:0];
    #1;
    chk("wx_col", weightMem_X, wx_col(ax));
    chk("wy_col", weightMem_Y, wy_col(ay));
    chk("bias", biasVec, bias_vec());
    chk("input_vec", LW'(inputVec), LW'(m_x[ax]));
    chk("prev_layer", LW'(prevLayerOut), LW'(m_h[ay]));
  endtask

  // Entered at START; runs the gate phase, ends in LOAD_X after dataReady_gate.
  task automatic busy_phase(input bit hv, input logic [LW-1:0] hvec);
    tick();
    chk("begin_one_shot", LW'(beginCalc), LW'(1'b0));
    for (int i = 0; i < 6; i++) begin
      loadValid = $urandom_range(0, 1);
      loadData = BW'($urandom);
      hiddenValid = hv && (i == 2);
      hiddenIn = hvec;
      check_reads();
      chk("busy_ready", LW'(loadReady), LW'(1'b0));
      tick();
    end
    loadValid = 1'b0;
    hiddenValid = 1'b0;
    dataReady_gate = 1'b1;
    tick();
    dataReady_gate = 1'b0;
    chk("turnaround_ready", LW'(loadReady), LW'(1'b1));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    words = 0;
    clear_model();
    chk("rst_ready", LW'(loadReady), LW'(1'b1));
    chk("rst_begin", LW'(beginCalc), LW'(1'b0));
    chk("rst_loaded", LW'(weightsLoaded), LW'(1'b0));
    check_reads();
    tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [LW-1:0] v800;
    reset = 1'b1;
    loadData = '0;
    loadValid = 1'b0;
    hiddenIn = '0;
    hiddenValid = 1'b0;
    colAddress_X = '0;
    colAddress_Y = '0;
    dataReady_gate = 1'b0;
    for (int r = 0; r < HS; r++) v800[r*BW +: BW] = 18'h00800;
    tick();
    do_reset();

    // Load with known patterns and a mid-W_y stall.
    for (int c = 0; c < IS; c++) for (int r = 0; r < HS; r++) m_wx[c][r] = BW'(c*16 + r);
    for (int c = 0; c < HS; c++) for (int r = 0; r < HS; r++) m_wy[c][r] = BW'(32'h100 + c*16 + r);
    for (int r = 0; r < HS; r++) m_b[r] = BW'(r);
    build_queue();
    stream_weights(NW, 100);
    stream_x(18'd5, 18'd7, 1'b0, '0);
    colAddress_Y = 4'd3;
    #1;
    chk("wy_c3_r2", LW'(weightMem_Y[2*BW +: BW]), LW'(18'h132));
    tick();
    // START -> BUSY happened on that tick; resume from BUSY directly.
    for (int i = 0; i < 4; i++) begin
      loadValid = ~loadValid;
      hiddenValid = (i == 1);
      hiddenIn = v800;
      check_reads();
      chk("busy_ready_t1", LW'(loadReady), LW'(1'b0));
      tick();
    end
    loadValid = 1'b0;
    hiddenValid = 1'b0;
    dataReady_gate = 1'b1;
    tick();
    dataReady_gate = 1'b0;
    chk("turnaround_t1", LW'(loadReady), LW'(1'b1));

    // h captured in LOAD_X.
    hiddenValid = 1'b1;
    hiddenIn = v800;
    tick();
    hiddenValid = 1'b0;
    set_h(v800);
    for (int a = 0; a < HS; a++) begin
      colAddress_Y = a[3:0];
      #1;
      chk("h_800", LW'(prevLayerOut), LW'(18'h00800));
      tick();
    end

    stream_x(18'h3FFFF, 18'd2, 1'b0, '0);
    colAddress_X = 1'b0;
    #1;
    chk("x0_neg_one", LW'(inputVec), LW'(18'h3FFFF));
    busy_phase(1'b1, rand_vec());

    // Random timesteps, sometimes with h arriving alongside the last x word.
    for (int t = 0; t < 5; t++) begin
      stream_x(BW'($urandom), BW'($urandom), bit'($urandom_range(0, 1)), rand_vec());
      busy_phase(1'b1, rand_vec());
    end

    // Reset part-way through W_y, then a fresh random load.
    do_reset();
    for (int c = 0; c < IS; c++) for (int r = 0; r < HS; r++) m_wx[c][r] = BW'($urandom);
    for (int c = 0; c < HS; c++) for (int r = 0; r < HS; r++) m_wy[c][r] = BW'($urandom);
    for (int r = 0; r < HS; r++) m_b[r] = BW'($urandom);
    build_queue();
    stream_weights(100, 0);
    do_reset();
    for (int c = 0; c < IS; c++) for (int r = 0; r < HS; r++) m_wx[c][r] = BW'($urandom);
    for (int c = 0; c < HS; c++) for (int r = 0; r < HS; r++) m_wy[c][r] = BW'($urandom);
    for (int r = 0; r < HS; r++) m_b[r] = BW'($urandom);
    build_queue();
    send_word(wq[0]);
    colAddress_X = 1'b0;
    #1;
    chk("wx00_after_reset", LW'(weightMem_X[BW-1:0]), LW'(m_wx[0][0]));
    tick();
    wq.pop_front();
    stream_weights(NW - 1, 0);
    stream_x(BW'($urandom), BW'($urandom), 1'b1, rand_vec());
    busy_phase(1'b1, rand_vec());
    check_reads();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
